cache_nway_lru: RTL

- Parametrised N-way set-associative write-back data cache array with true-LRU replacement.
- Adds a locked multi-word line-fill sequence and a whole-cache flush sweep.
- Sits between the CPU load/store path and the cache controller FSM.
- The controller drives all commands. This block holds tag, data, valid, dirty and age state and reports hit, victim and writeback data.

---
 rtl/cache_nway_lru.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back data cache array with true-LRU replacement,
// a locked multi-word line fill and a whole-cache flush sweep.
module cache_nway_lru #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned SET_BITS  = 5,
    parameter int unsigned WORD_BITS = 2,
    localparam int unsigned WAY_BITS = $clog2(WAYS),
    localparam int unsigned TAG_BITS = ADDR_BITS - SET_BITS - WORD_BITS - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 load,
    input  logic                 edit,
    input  logic                 fill_start,
    input  logic                 store,
    input  logic                 invalid,
    input  logic                 flush_all,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          din,
    output logic                 busy,
    output logic                 fill_active,
    output logic                 hit,
    output logic [WAY_BITS-1:0]  hit_way,
    output logic [WAY_BITS-1:0]  victim_way,
    output logic [31:0]          dout,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag
);

    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned WORDS = 1 << WORD_BITS;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state;
    logic [SET_BITS-1:0] sweep_set;
    logic [WAY_BITS-1:0] fill_way;
    logic [SET_BITS-1:0] fill_set;

    logic [31:0]          data_q  [SETS][WAYS][WORDS];
    logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
    logic                 valid_q [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic [WAY_BITS-1:0]  age_q   [SETS][WAYS];

    logic [TAG_BITS-1:0]  a_tag;
    logic [SET_BITS-1:0]  a_set;
    logic [WORD_BITS-1:0] a_word;
    logic [1:0]           a_byte;

    assign a_tag  = addr[ADDR_BITS-1 -: TAG_BITS];
    assign a_set  = addr[WORD_BITS+2 +: SET_BITS];
    assign a_word = addr[2 +: WORD_BITS];
    assign a_byte = addr[1:0];

    logic                cmd_ok;
    logic [WAYS-1:0]     way_hit;
    logic                hit_c;
    logic [WAY_BITS-1:0] hit_w;
    logic                inv_found;
    logic [WAY_BITS-1:0] store_way;
    logic [31:0]         rd_word;
    logic [31:0]         wb_word;
    logic [31:0]         load_data;
    logic [31:0]         merged;
    logic [15:0]         half_v;
    logic [7:0]          byte_v;
    logic [WAY_BITS-1:0] touch_way;
    logic [WAY_BITS-1:0] touch_age;
    logic [WAY_BITS-1:0] new_age [WAYS];

    assign cmd_ok = (state == IDLE) && !flush_all;

    // Tag compare; a way still being filled never reports a hit.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            way_hit[i] = valid_q[a_set][i] && (tag_q[a_set][i] == a_tag) &&
                         !(fill_active && (fill_way == WAY_BITS'(i)));
        end
        hit_c = 1'b0;
        hit_w = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_c = 1'b1;
                hit_w = WAY_BITS'(i);
            end
        end
    end

    // Replacement choice: lowest invalid way, else oldest, fill way while locked.
    always_comb begin
        victim_way = '0;
        inv_found  = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[a_set][i]) begin
                victim_way = WAY_BITS'(i);
                inv_found  = 1'b1;
            end
        end
        if (!inv_found) begin
            for (int i = 0; i < WAYS; i++) begin
                if (age_q[a_set][i] == WAY_BITS'(WAYS - 1)) begin
                    victim_way = WAY_BITS'(i);
                end
            end
        end
        if (fill_active && (fill_set == a_set)) begin
            victim_way = fill_way;
        end
    end

    assign store_way = fill_active ? fill_way : victim_way;
    assign rd_word   = data_q[a_set][hit_w][a_word];
    assign wb_word   = data_q[a_set][victim_way][a_word];

    // Load extraction with sign/zero extension, and store-on-hit lane merge.
    always_comb begin
        half_v = a_byte[1] ? rd_word[31:16] : rd_word[15:0];
        case (a_byte)
            2'd0:    byte_v = rd_word[7:0];
            2'd1:    byte_v = rd_word[15:8];
            2'd2:    byte_v = rd_word[23:16];
            default: byte_v = rd_word[31:24];
        endcase
        load_data = rd_word;
        if (!u_b_h_w[1]) begin
            if (u_b_h_w[0]) begin
                load_data = u_b_h_w[2] ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
            end else begin
                load_data = u_b_h_w[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
        end

        merged = rd_word;
        if (u_b_h_w[1]) begin
            merged = din;
        end else if (u_b_h_w[0]) begin
            if (a_byte[1]) merged[31:16] = din[15:0];
            else           merged[15:0]  = din[15:0];
        end else begin
            case (a_byte)
                2'd0:    merged[7:0]   = din[7:0];
                2'd1:    merged[15:8]  = din[7:0];
                2'd2:    merged[23:16] = din[7:0];
                default: merged[31:24] = din[7:0];
            endcase
        end
    end

    // Ages after touching one way of addr's set.
    always_comb begin
        touch_way = store ? fill_way : hit_w;
        touch_age = age_q[a_set][touch_way];
        for (int j = 0; j < WAYS; j++) begin
            if (WAY_BITS'(j) == touch_way) begin
                new_age[j] = '0;
            end else if (age_q[a_set][j] < touch_age) begin
                new_age[j] = age_q[a_set][j] + WAY_BITS'(1);
            end else begin
                new_age[j] = age_q[a_set][j];
            end
        end
    end

    // Data and tag arrays are left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (rst && cmd_ok && !invalid) begin
            if (store) begin
                data_q[a_set][store_way][a_word] <= din;
                tag_q[a_set][store_way]          <= a_tag;
            end else if (edit && hit_c) begin
                data_q[a_set][hit_w][a_word] <= merged;
            end
        end
    end

    // Control state, per-line state bits, ages and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sweep_set   <= '0;
            busy        <= 1'b0;
            fill_active <= 1'b0;
            fill_way    <= '0;
            fill_set    <= '0;
            hit         <= 1'b0;
            hit_way     <= '0;
            dout        <= '0;
            valid       <= 1'b0;
            dirty       <= 1'b0;
            tag         <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_BITS'(w);
                end
            end
        end else begin
            valid <= valid_q[a_set][victim_way];
            dirty <= dirty_q[a_set][victim_way];
            tag   <= tag_q[a_set][victim_way];
            case (state)
                SWEEP: begin
                    hit <= 1'b0;
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[sweep_set][w] <= 1'b0;
                        dirty_q[sweep_set][w] <= 1'b0;
                        age_q[sweep_set][w]   <= WAY_BITS'(w);
                    end
                    sweep_set <= sweep_set + SET_BITS'(1);
                    if (sweep_set == SET_BITS'(SETS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (flush_all) begin
                        state       <= SWEEP;
                        sweep_set   <= '0;
                        busy        <= 1'b1;
                        fill_active <= 1'b0;
                        hit         <= 1'b0;
                    end else begin
                        hit     <= hit_c;
                        hit_way <= hit_w;
                        if (load && hit_c) begin
                            dout <= load_data;
                        end else if (!load) begin
                            dout <= wb_word;
                        end
                        if (fill_start && !fill_active) begin
                            fill_active <= 1'b1;
                            fill_way    <= victim_way;
                            fill_set    <= a_set;
                        end
                        if (invalid) begin
                            for (int w = 0; w < WAYS; w++) begin
                                valid_q[a_set][w] <= 1'b0;
                                dirty_q[a_set][w] <= 1'b0;
                                age_q[a_set][w]   <= WAY_BITS'(w);
                            end
                        end else if (store) begin
                            valid_q[a_set][store_way] <= 1'b1;
                            dirty_q[a_set][store_way] <= 1'b0;
                            if (fill_active && (&a_word)) begin
                                fill_active <= 1'b0;
                                for (int j = 0; j < WAYS; j++) begin
                                    age_q[a_set][j] <= new_age[j];
                                end
                            end
                        end else if (hit_c && (edit || load)) begin
                            if (edit) begin
                                dirty_q[a_set][hit_w] <= 1'b1;
                            end
                            for (int j = 0; j < WAYS; j++) begin
                                age_q[a_set][j] <= new_age[j];
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
